// File: rtl/processor_a.sv
// Pivot (diagonal) cell of the GF(2^WIDTH) systolic eliminator: per row it chooses
// pass / normalize / eliminate and hands the op and factor to the processor_B chain.

module gfe_inv #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Low WIDTH bits of a primitive polynomial; the x^WIDTH term is implicit.
    function automatic logic [WIDTH-1:0] field_poly();
        case (WIDTH)
            1:       return WIDTH'(32'h1);
            2:       return WIDTH'(32'h3);
            3:       return WIDTH'(32'h3);
            4:       return WIDTH'(32'h3);
            5:       return WIDTH'(32'h5);
            6:       return WIDTH'(32'h3);
            7:       return WIDTH'(32'h9);
            8:       return WIDTH'(32'h1d);
            9:       return WIDTH'(32'h11);
            10:      return WIDTH'(32'h9);
            11:      return WIDTH'(32'h5);
            12:      return WIDTH'(32'h53);
            13:      return WIDTH'(32'h1b);
            14:      return WIDTH'(32'h2b);
            15:      return WIDTH'(32'h3);
            16:      return WIDTH'(32'h100b);
            default: return WIDTH'(32'h3);
        endcase
    endfunction

    localparam logic [WIDTH-1:0] POLY = field_poly();

    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] sh;
        logic [WIDTH:0]   t;
        acc = '0;
        sh  = x;
        for (int i = 0; i < WIDTH; i++) begin
            if (z[i]) acc = acc ^ sh;
            t  = {sh, 1'b0};
            sh = t[WIDTH-1:0] ^ (t[WIDTH] ? POLY : '0);
        end
        return acc;
    endfunction

    // a^(2^m - 2) = product of a^(2^i) for i = 1..m-1; zero maps to zero.
    function automatic logic [WIDTH-1:0] gf_inv(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] sq;
        res = WIDTH'(1);
        sq  = x;
        for (int i = 1; i < WIDTH; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return (x == '0) ? '0 : res;
    endfunction

    always_comb begin
        y = gf_inv(a);
    end

endmodule

module processor_a #(
    parameter int WIDTH = 1,
    parameter int ROWS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start_in,
    output logic [1:0]       op_out,
    output logic [WIDTH-1:0] fac_out,
    output logic             start_out,
    output logic             r,
    output logic             fail
);

    // Timing contract: no handshake. One row is accepted every cycle and its
    // op/fac/start_out appear on the next cycle; nothing can stall the chain.

    localparam int CW = $clog2(ROWS + 1);
    localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ELIM = 2'b10;
    localparam logic [1:0] OP_NORM = 2'b11;

    typedef enum logic {
        SEEK = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           eff;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [1:0]       op_nxt;
    logic [WIDTH-1:0] fac_nxt;
    logic [WIDTH-1:0] inv_data;
    logic             r_nxt;
    logic             fail_nxt;

    gfe_inv #(.WIDTH(WIDTH)) u_inv (
        .a (data_in),
        .y (inv_data)
    );

    always_comb begin
        eff       = start_in ? SEEK : state;
        state_nxt = eff;
        op_nxt    = OP_PASS;
        fac_nxt   = '0;
        r_nxt     = start_in ? 1'b0 : r;
        case (eff)
            SEEK: begin
                if (data_in != '0) begin
                    op_nxt    = OP_NORM;
                    fac_nxt   = inv_data;
                    r_nxt     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                op_nxt  = OP_ELIM;
                fac_nxt = data_in;
            end
            default: ;
        endcase
        if (start_in) begin
            cnt_nxt = CW'(1);
        end else if (cnt == ROWS_C) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        // A full column's worth of rows with no pivot latches fail until the next start.
        fail_nxt = (start_in ? 1'b0 : fail) | ((cnt_nxt == ROWS_C) && (state_nxt == SEEK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEEK;
            cnt       <= '0;
            op_out    <= OP_PASS;
            fac_out   <= '0;
            start_out <= 1'b0;
            r         <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_out    <= op_nxt;
            fac_out   <= fac_nxt;
            start_out <= start_in;
            r         <= r_nxt;
            fail      <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_processor_a.sv
// Bench for processor_a: GF(16) build checked by a scoreboard against a row-level
// model, plus a GF(2) build for the single-bit field case.

module tb_processor_a;

    localparam int W    = 4;
    localparam int ROWS = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         start_in;
    logic [1:0]   op_out;
    logic [W-1:0] fac_out;
    logic         start_out;
    logic         r;
    logic         fail;

    logic         s1_rst;
    logic [0:0]   s1_data;
    logic         s1_start;
    logic [1:0]   o1_op;
    logic [0:0]   o1_fac;
    logic         o1_start;
    logic         o1_r;
    logic         o1_fail;

    int tests_run = 0;
    int tests_failed = 0;

    logic [8:0] exp_q[$];

    processor_a #(.WIDTH(W), .ROWS(ROWS)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .start_in  (start_in),
        .op_out    (op_out),
        .fac_out   (fac_out),
        .start_out (start_out),
        .r         (r),
        .fail      (fail)
    );

    processor_a #(.WIDTH(1), .ROWS(ROWS)) u_dut1 (
        .clk       (clk),
        .rst       (s1_rst),
        .data_in   (s1_data),
        .start_in  (s1_start),
        .op_out    (o1_op),
        .fac_out   (o1_fac),
        .start_out (o1_start),
        .r         (o1_r),
        .fail      (o1_fail)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: GF(16) with x^4+x+1, inverse by exhaustive search
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = 0;
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ (int'(a) << i);
        for (int k = 2 * W - 2; k >= W; k--)
            if (((p >> k) & 1) != 0) p = p ^ (32'h13 << (k - W));
        return W'(p);
    endfunction

    function automatic logic [W-1:0] ref_inv(input logic [W-1:0] a);
        for (int b = 1; b < (1 << W); b++)
            if (ref_mul(a, W'(b)) == W'(1)) return W'(b);
        return '0;
    endfunction

    bit m_found;
    int m_rows;
    bit m_r;
    bit m_fail;

    task automatic step(input logic rst_v, input logic st, input logic [W-1:0] d);
        logic [1:0]   e_op;
        logic [W-1:0] e_fac;
        @(negedge clk);
        rst      = rst_v;
        start_in = st;
        data_in  = d;
        e_op  = 2'b00;
        e_fac = '0;
        if (rst_v) begin
            m_found = 0; m_rows = 0; m_r = 0; m_fail = 0;
            exp_q.push_back(9'b0);
        end else begin
            if (st) begin
                m_found = 0; m_rows = 0; m_r = 0; m_fail = 0;
            end
            if (m_rows < ROWS) m_rows++;
            if (m_found) begin
                e_op  = 2'b10;
                e_fac = d;
            end else if (d != '0) begin
                e_op    = 2'b11;
                e_fac   = ref_inv(d);
                m_found = 1;
                m_r     = 1;
            end
            if (m_rows == ROWS && !m_found) m_fail = 1;
            exp_q.push_back({e_op, e_fac, st, m_r, m_fail});
        end
    endtask

    // monitor: every cycle the DUT presents one row result
    initial begin
        logic [8:0] got;
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {op_out, fac_out, start_out, r, fail};
                tests_run++;
                if (got !== e) begin
                    tests_failed++;
                    $display("FAIL sb row: got op=%b fac=%0d start=%b r=%b fail=%b, exp op=%b fac=%0d start=%b r=%b fail=%b",
                             got[8:7], got[6:3], got[2], got[1], got[0], e[8:7], e[6:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] e);
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL %s: got %0h exp %0h", name, got, e);
        end
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b1; data_in = 4'd5;
        s1_rst = 1'b1; s1_start = 1'b0; s1_data = 1'b0;
        m_found = 0; m_rows = 0; m_r = 0; m_fail = 0;

        // reset with start/data active
        step(1, 1, 5); step(1, 1, 5);
        // immediate pivot
        step(0, 1, 2); step(0, 0, 3); step(0, 0, 0); step(0, 0, 7);
        // delayed pivot
        step(0, 1, 0); step(0, 0, 0); step(0, 0, 6); step(0, 0, 1);
        // singular column, held fail, then recovery
        step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 0); step(0, 1, 1);
        // back-to-back starts
        step(0, 1, 4); step(0, 1, 0);
        // late pivot after saturation keeps fail
        step(0, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 0); step(0, 0, 5); step(0, 0, 9);
        // reset mid-matrix, then pivot without start
        step(0, 1, 3); step(0, 0, 1); step(1, 0, 9); step(0, 0, 5); step(0, 0, 2);

        // random stream
        for (int i = 0; i < 400; i++) begin
            logic rr;
            logic ss;
            logic [W-1:0] dd;
            rr = ($urandom_range(0, 49) == 0);
            ss = ($urandom_range(0, 4) == 0);
            dd = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(0, 15));
            step(rr, ss, dd);
        end

        // GF(2) build
        @(negedge clk);
        s1_rst = 1'b0; s1_start = 1'b1; s1_data = 1'b1;
        @(posedge clk); #1;
        check("w1 op", {6'b0, o1_op}, 8'h3);
        check("w1 fac", {7'b0, o1_fac}, 8'h1);
        check("w1 r", {7'b0, o1_r}, 8'h1);
        @(negedge clk);
        s1_start = 1'b0; s1_data = 1'b1;
        @(posedge clk); #1;
        check("w1 elim op", {6'b0, o1_op}, 8'h2);
        check("w1 elim fac", {7'b0, o1_fac}, 8'h1);
        @(negedge clk);
        s1_start = 1'b1; s1_data = 1'b0;
        @(posedge clk); #1;
        check("w1 seek op", {6'b0, o1_op}, 8'h0);
        check("w1 seek r", {7'b0, o1_r}, 8'h0);

        repeat (3) @(posedge clk);
        #2;
        check("sb drain", 8'(exp_q.size()), 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/processor_a.md
Name: processor_A

Overview:
- Diagonal (pivot) cell of the single-pass GF(2^WIDTH) systolic eliminator. Sits directly upstream of each row of processor_B cells.
- Consumes one pivot-column element per cycle. Decides pass/swap-normalize/eliminate and emits the per-row op code and multiplier factor that the processor_B chain applies to the remaining columns.
- Also tracks pivot presence and flags a column with no non-zero pivot across ROWS rows (matrix not systematic).

Parameters:
- WIDTH, 1, field element width m of GF(2^m); field polynomial is the one used by GFE_mad/GFE_inv.
- ROWS, 4, rows per matrix; used for the pivot-failure check.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- data_in  input  WIDTH  pivot-column element of the current row.
- start_in  input  1  high on the first row of a new matrix.
- op_out  output  2  registered op for downstream processor_B: 00 pass, 01 swap (unused here), 10 eliminate, 11 inv-add/normalize.
- fac_out  output  WIDTH  registered factor for downstream processor_B.
- start_out  output  1  start_in delayed by 1 cycle.
- r  output  1  pivot-found flag for the current matrix.
- fail  output  1  sticky: ROWS rows seen with no pivot; cleared by the next start_in.

Behaviour:
- One clock domain. Synchronous active-high reset.
- rst=1 forces: state=SEEK, row counter=0, op_out=00, fac_out=0, start_out=0, r=0, fail=0.
- rst has priority over start_in.
- All outputs are registered, so latency is exactly 1 cycle from data_in/start_in to op_out/fac_out/start_out. A row enters every cycle; there is no stall.
- Inverse: combinational instance of GFE_inv (GF(2^WIDTH), inv(0)=0). Its result is registered into fac_out.
- Effective state: eff = SEEK when start_in=1, otherwise the stored state.
- State machine (states SEEK, HOLD), evaluated on eff each cycle:
  - SEEK, data_in==0: op_out<=00, fac_out<=0. State stays SEEK.
  - SEEK, data_in!=0: op_out<=11, fac_out<=inv(data_in), r<=1. State goes to HOLD. This row becomes the stored pivot row downstream, normalized so its pivot is 1.
  - HOLD, any data_in: op_out<=10, fac_out<=data_in. Downstream computes r_reg*fac+data, clearing this row's pivot-column entry. data_in==0 still yields op 10 with fac 0, which is a no-op add.
- start_in=1 also clears r and fail in the same cycle before the SEEK decision. So start with non-zero data gives r<=1, op 11.
- Row counter cnt (width clog2(ROWS+1)):
  - start_in=1 loads cnt<=1.
  - Otherwise cnt increments each cycle, saturating at ROWS.
- fail<=1 when the updated cnt equals ROWS and the state after this cycle is still SEEK. fail holds until rst or start_in.
- A matrix longer than ROWS rows without start: the counter saturates; a late pivot still sets r and HOLD, but fail remains set.
- start_out<=start_in. No back-to-back hazards: start on consecutive cycles gives each cycle a fresh SEEK decision.
- Reset mid-matrix abandons the matrix. The next valid decision requires start_in.
- WIDTH=1: inv(1)=1, so op 11 carries fac_out=1.

Test Plan:
- Test config for field cases: WIDTH=4, polynomial x^4+x+1.
- Reset: hold rst 2 cycles with data_in=5, start_in=1 -> op_out=00, fac_out=0, start_out=0, r=0, fail=0.
- Immediate pivot: start_in=1, data_in=2, then rows 3,0,7 -> op/fac sequence (11,9),(10,3),(10,0),(10,7), each 1 cycle late; start_out high only in the first output cycle; r=1; fail=0.
- Delayed pivot: start, rows 0,0,6,1 -> (00,0),(00,0),(11,inv(6)=7),(10,1); fail stays 0.
- Singular column: start, rows 0,0,0,0 (ROWS=4) -> four (00,0) outputs; fail=1 in the cycle after the 4th row and held; next start_in with data 1 -> fail=0, r=1, op 11, fac 1.
- Back-to-back matrices: start with 4 then start with 0 on the next cycle -> (11,inv(4)=13) then (00,0); r goes 1 then 0.
- Reset mid-operation: in HOLD assert rst for 1 cycle, then data 5 without start -> outputs zero during reset, then (11,inv(5)=11), state SEEK on entry; WIDTH=1 build with start, data 1 -> (11,1).
